// File: rtl/pr_pkg.sv
// Shared types and arithmetic helpers for the PageRank rank-update block.
package pr_pkg;

  localparam int FRAC_DEF = 16;

  typedef enum logic [1:0] {
    ACCUM,
    SCALE,
    OUT
  } state_t;

  // round(2^frac / k); k=0 maps to 0 so dangling sources add nothing
  function automatic logic [63:0] recip(input int k, input int frac);
    if (k <= 0) return 64'd0;
    return ((64'd1 << frac) + 64'(k / 2)) / 64'(k);
  endfunction

  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          w
  );
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

endpackage

// File: rtl/pr_sat_mul_shift.sv
// Unsigned fixed-point multiply: (a*b)>>FRAC, saturating to all-ones.
module pr_sat_mul_shift #(
  parameter int NBITS = 32,
  parameter int FRAC  = 16
) (
  input  logic [NBITS-1:0] i_a,
  input  logic [NBITS-1:0] i_b,
  output logic [NBITS-1:0] o_y
);

  logic [2*NBITS-1:0] w_prod;
  logic [2*NBITS-1:0] w_shr;

  assign w_prod = {{NBITS{1'b0}}, i_a} * {{NBITS{1'b0}}, i_b};
  assign w_shr  = w_prod >> FRAC;
  assign o_y    = (|w_shr[2*NBITS-1:NBITS]) ? '1 : w_shr[NBITS-1:0];

endmodule

// File: rtl/pagerank_rank_update.sv
// One PageRank iteration over 8 nodes: scatter-accumulate, damp, present.
module pagerank_rank_update
  import pr_pkg::*;
#(
  parameter int nbits = 32,
  parameter int FRAC  = FRAC_DEF,
  parameter int DAMP  = 55706,
  parameter int BASE  = 1229
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_rank,
  input  logic [7:0]       in_mask,
  input  logic             in_last,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out_rank0,
  output logic [nbits-1:0] out_rank1,
  output logic [nbits-1:0] out_rank2,
  output logic [nbits-1:0] out_rank3,
  output logic [nbits-1:0] out_rank4,
  output logic [nbits-1:0] out_rank5,
  output logic [nbits-1:0] out_rank6,
  output logic [nbits-1:0] out_rank7
);

  localparam logic [nbits-1:0] RECIP [9] = '{
    nbits'(recip(0, FRAC)), nbits'(recip(1, FRAC)),
    nbits'(recip(2, FRAC)), nbits'(recip(3, FRAC)),
    nbits'(recip(4, FRAC)), nbits'(recip(5, FRAC)),
    nbits'(recip(6, FRAC)), nbits'(recip(7, FRAC)),
    nbits'(recip(8, FRAC))
  };
  localparam logic [nbits-1:0] W_DAMP = nbits'(DAMP);
  localparam logic [63:0]      W_BASE = 64'(BASE);

  state_t           r_state;
  state_t           w_next;
  logic [nbits-1:0] r_acc [8];
  logic [nbits-1:0] r_out [8];
  logic [2:0]       r_cnt;

  logic             w_hs_in;
  logic             w_hs_out;
  logic [3:0]       w_k;
  logic [nbits-1:0] w_recip;
  logic [nbits-1:0] w_c;
  logic [nbits-1:0] w_damp;

  assign w_hs_in  = in_val & in_rdy;
  assign w_hs_out = out_val & out_rdy;
  assign w_k      = popcount8(in_mask);
  assign w_recip  = RECIP[w_k];

  pr_sat_mul_shift #(.NBITS(nbits), .FRAC(FRAC)) u_contrib (
    .i_a (in_rank),
    .i_b (w_recip),
    .o_y (w_c)
  );

  pr_sat_mul_shift #(.NBITS(nbits), .FRAC(FRAC)) u_damp (
    .i_a (W_DAMP),
    .i_b (r_acc[r_cnt]),
    .o_y (w_damp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACCUM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    unique case (r_state)
      ACCUM: begin
        in_rdy = 1'b1;
        if (in_val && in_last) w_next = SCALE;
      end
      SCALE: begin
        if (r_cnt == 3'd7) w_next = OUT;
      end
      OUT: begin
        out_val = 1'b1;
        if (out_rdy) w_next = ACCUM;
      end
      default: w_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      for (int i = 0; i < 8; i++) begin
        r_acc[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      if (w_hs_in) begin
        for (int i = 0; i < 8; i++)
          if (in_mask[i])
            r_acc[i] <= nbits'(sat_add(64'(r_acc[i]), 64'(w_c), nbits));
        if (in_last) r_cnt <= '0;
      end
      if (r_state == SCALE) begin
        r_out[r_cnt] <= nbits'(sat_add(W_BASE, 64'(w_damp), nbits));
        r_cnt        <= r_cnt + 3'd1;
      end
      // results stay visible; only the sums restart
      if (w_hs_out)
        for (int i = 0; i < 8; i++) r_acc[i] <= '0;
    end
  end

  assign out_rank0 = r_out[0];
  assign out_rank1 = r_out[1];
  assign out_rank2 = r_out[2];
  assign out_rank3 = r_out[3];
  assign out_rank4 = r_out[4];
  assign out_rank5 = r_out[5];
  assign out_rank6 = r_out[6];
  assign out_rank7 = r_out[7];

endmodule

// File: tb/tb_pagerank_rank_update.sv
// Bench for pagerank_rank_update: vector table, corner sequences, random vs model.
module tb_pagerank_rank_update;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic        in_last = 1'b0;
  logic        out_rdy = 1'b0;
  logic [31:0] in_rank = '0;
  logic [7:0]  in_mask = '0;
  logic        in_rdy;
  logic        out_val;
  logic [31:0] o [8];

  int n_tests = 0;
  int n_fail  = 0;

  localparam longint unsigned MAXV = 64'hFFFF_FFFF;
  longint unsigned recip_t [9] = '{0, 65536, 32768, 21845, 16384,
                                   13107, 10923, 9362, 8192};

  logic [31:0] q_rank [$];
  logic [7:0]  q_mask [$];

  typedef struct {
    logic [31:0] rank;
    logic [7:0]  mask;
    logic [31:0] hit;
    logic [31:0] miss;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  pagerank_rank_update dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_rank   (in_rank),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_rank0 (o[0]),
    .out_rank1 (o[1]),
    .out_rank2 (o[2]),
    .out_rank3 (o[3]),
    .out_rank4 (o[4]),
    .out_rank5 (o[5]),
    .out_rank6 (o[6]),
    .out_rank7 (o[7])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the queued beats of one iteration
  function automatic void model(output logic [31:0] e [8]);
    longint unsigned acc [8];
    longint unsigned c;
    int k;
    for (int i = 0; i < 8; i++) acc[i] = 0;
    for (int b = 0; b < q_rank.size(); b++) begin
      k = $countones(q_mask[b]);
      c = q_rank[b];
      c = (c * recip_t[k]) >> 16;
      if (c > MAXV) c = MAXV;
      for (int i = 0; i < 8; i++)
        if (q_mask[b][i]) begin
          acc[i] = acc[i] + c;
          if (acc[i] > MAXV) acc[i] = MAXV;
        end
    end
    for (int i = 0; i < 8; i++) begin
      c = 1229 + ((55706 * acc[i]) >> 16);
      e[i] = (c > MAXV) ? 32'hFFFF_FFFF : c[31:0];
    end
  endfunction

  task automatic send_beats(input bit gaps);
    int t;
    for (int i = 0; i < q_rank.size(); i++) begin
      t = 0;
      while (!in_rdy && t < 50) begin
        step();
        t++;
      end
      chk("in_rdy_wait", 64'(in_rdy), 64'd1);
      in_val  = 1'b1;
      in_rank = q_rank[i];
      in_mask = q_mask[i];
      in_last = (i == q_rank.size() - 1);
      step();
      in_val  = 1'b0;
      in_last = 1'b0;
      if (gaps && i < q_rank.size() - 1) begin
        repeat ($urandom_range(0, 2)) begin
          in_last = 1'($urandom_range(0, 1));
          in_rank = $urandom;
          in_mask = 8'($urandom_range(0, 255));
          step();
        end
        in_last = 1'b0;
      end
    end
  endtask

  task automatic wait_out(input bit lat_chk);
    int lat;
    lat = 1;
    while (!out_val && lat < 40) begin
      step();
      lat++;
    end
    chk("out_val_seen", 64'(out_val), 64'd1);
    if (lat_chk) chk("latency", 64'(lat), 64'd9);
  endtask

  task automatic finish_iter(input int hold);
    logic [31:0] snap [8];
    snap = o;
    repeat (hold) begin
      in_val  = 1'($urandom_range(0, 1));
      in_rank = $urandom;
      in_mask = 8'($urandom_range(0, 255));
      in_last = 1'b1;
      chk("bp_out_val", 64'(out_val), 64'd1);
      chk("bp_in_rdy", 64'(in_rdy), 64'd0);
      step();
    end
    in_val  = 1'b0;
    in_last = 1'b0;
    if (hold > 0)
      for (int i = 0; i < 8; i++) chk("bp_stable", 64'(o[i]), 64'(snap[i]));
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("in_rdy_after_hs", 64'(in_rdy), 64'd1);
    chk("out_val_after_hs", 64'(out_val), 64'd0);
    chk("hold_after_hs", 64'(o[0]), 64'(snap[0]));
  endtask

  task automatic single_8192(input string nm);
    q_rank = {32'h0001_0000};
    q_mask = {8'hFF};
    send_beats(1'b0);
    wait_out(1'b1);
    for (int i = 0; i < 8; i++) chk(nm, 64'(o[i]), 64'd8192);
    finish_iter(0);
  endtask

  initial begin
    logic [31:0] e [8];
    logic [31:0] exp_v;

    vecs[0] = '{32'h0001_0000, 8'hFF, 32'd8192,  32'd8192};
    vecs[1] = '{32'h0001_0000, 8'h00, 32'd1229,  32'd1229};
    vecs[2] = '{32'h0002_0000, 8'h01, 32'd112641, 32'd1229};
    vecs[3] = '{32'h0003_0000, 8'h07, 32'd56934, 32'd1229};

    // reset state
    step();
    step();
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_val", 64'(out_val), 64'd0);
    for (int i = 0; i < 8; i++) chk("rst_out_rank", 64'(o[i]), 64'd0);
    reset = 1'b0;
    step();

    // single-beat vector table
    for (int v = 0; v < 4; v++) begin
      q_rank = {vecs[v].rank};
      q_mask = {vecs[v].mask};
      send_beats(1'b0);
      wait_out(1'b1);
      for (int i = 0; i < 8; i++) begin
        exp_v = vecs[v].mask[i] ? vecs[v].hit : vecs[v].miss;
        chk($sformatf("vec%0d_n%0d", v, i), 64'(o[i]), 64'(exp_v));
      end
      finish_iter(0);
    end

    // two beats
    q_rank = {32'h0001_0000, 32'h0000_8000};
    q_mask = {8'h01, 8'h03};
    send_beats(1'b0);
    wait_out(1'b1);
    chk("two_n0", 64'(o[0]), 64'd70861);
    chk("two_n1", 64'(o[1]), 64'd15155);
    for (int i = 2; i < 8; i++) chk("two_rest", 64'(o[i]), 64'd1229);
    finish_iter(0);

    // accumulator saturation
    q_rank = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    q_mask = {8'h01, 8'h01};
    send_beats(1'b0);
    wait_out(1'b1);
    chk("sat_n0", 64'(o[0]), 64'd3650749644);
    for (int i = 1; i < 8; i++) chk("sat_rest", 64'(o[i]), 64'd1229);
    finish_iter(0);

    // backpressure, then rerun confirms accumulators cleared
    q_rank = {32'h0001_0000};
    q_mask = {8'hFF};
    send_beats(1'b0);
    wait_out(1'b1);
    finish_iter(5);
    single_8192("bp_rerun");

    // reset in SCALE cycle 3
    q_rank = {32'h0001_0000};
    q_mask = {8'hFF};
    send_beats(1'b0);
    step();
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_out_val", 64'(out_val), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    for (int i = 0; i < 8; i++) chk("mid_rst_out", 64'(o[i]), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("post_rst_out_val", 64'(out_val), 64'd0);
    single_8192("rst_rerun");

    // randomized iterations against the model
    for (int it = 0; it < 40; it++) begin
      q_rank.delete();
      q_mask.delete();
      repeat ($urandom_range(1, 6)) begin
        if ($urandom_range(0, 3) == 0) q_rank.push_back($urandom);
        else q_rank.push_back(32'($urandom_range(0, 32'h0004_0000)));
        q_mask.push_back(8'($urandom_range(0, 255)));
      end
      send_beats(1'b1);
      wait_out(1'b1);
      model(e);
      for (int i = 0; i < 8; i++)
        chk($sformatf("rnd%0d_n%0d", it, i), 64'(o[i]), 64'(e[i]));
      finish_iter($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
